// File: rtl/mux41_arb.sv
// ---------------------------------------------------------------------------
// mux41_arb
//   Round-robin arbiter that owns the select lines of a 4:1 mux. One requester
//   at a time gets the grant. The grant is held while the owner keeps
//   requesting. It is taken away after MAX_HOLD cycles if someone else is
//   waiting. Every grant is followed by a one-cycle gap before the next one.
//
// Parameters
//   MAX_HOLD : cycles an owner may keep the grant while others wait (1..255)
//
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   req   : request per requester (bit0=a ... bit3=d)
//   gnt   : one-hot grant (registered)
//   s0    : mux select, high for owners 2 and 3 (registered)
//   s1    : mux select, high for owners 1 and 3 (registered)
//   busy  : high while a grant is active (registered)
// ---------------------------------------------------------------------------
module mux41_arb #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [7:0] hold_q,  hold_d;
    logic [3:0] gnt_q,   gnt_d;
    logic       busy_q,  busy_d;

    logic [1:0] winner;
    logic [3:0] others;

    // First set request bit found when searching ptr, ptr+1, ... mod 4.
    // The scan runs from the farthest position inwards, so the nearest
    // hit is the last one written and wins.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] idx;
        w = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    assign winner = pick(req, ptr_q);
    assign others = req & ~(4'b0001 << owner_q);

    // NOTE: every signal driven here gets its default first. Any path that
    // left one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;

        unique case (state_q)
            // IDLE and GAP arbitrate identically. GAP exists only so that
            // a release edge can never issue a new grant by itself.
            IDLE, GAP: begin
                if (|req) begin
                    state_d = GRANT;
                    owner_d = winner;
                    hold_d  = 8'd1;
                    gnt_d   = 4'b0001 << winner;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                if (!req[owner_q] || (hold_q == HOLD_MAX && |others)) begin
                    state_d = GAP;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                    ptr_d   = owner_q + 2'd1;   // 3 wraps to 0
                end else if (hold_q != HOLD_MAX) begin
                    hold_d  = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments. All flops then
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            hold_q  <= 8'd0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    // The selects come straight from the owner register. They keep the last
    // owner through GAP and IDLE, and they cannot move while busy.
    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign s0   = owner_q[1];
    assign s1   = owner_q[0];

endmodule
